instr_mem_ctrl: RTL and testbench

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

---
 rtl/instr_mem_ctrl_if.sv | 29 ++
 rtl/instr_mem_ctrl.sv | 91 +++++++++
 tb/tb_instr_mem_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_ctrl_if.sv
// rtl/instr_mem_ctrl_if.sv - host load port and fetch port bundle for instr_mem_ctrl
interface instr_mem_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  load_valid_i;
    logic [DATA_WIDTH-1:0] load_data_i;
    logic                  load_last_i;
    logic                  load_ready_o;
    logic                  reload_i;
    logic [ADDR_WIDTH-1:0] im_addr_i;
    logic                  im_rd_i;
    logic [DATA_WIDTH-1:0] im_data_o;
    logic                  im_valid_o;
    logic                  start_o;
    logic [ADDR_WIDTH:0]   load_count_o;
    logic                  load_err_o;
    logic [1:0]            state_o;

    modport master (
        output load_valid_i, load_data_i, load_last_i, reload_i, im_addr_i, im_rd_i,
        input  load_ready_o, im_data_o, im_valid_o, start_o, load_count_o, load_err_o, state_o
    );

    modport slave (
        input  load_valid_i, load_data_i, load_last_i, reload_i, im_addr_i, im_rd_i,
        output load_ready_o, im_data_o, im_valid_o, start_o, load_count_o, load_err_o, state_o
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - loadable instruction memory with EMPTY/LOAD/READY sequencing and 1-cycle fetch
module instr_mem_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    instr_mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LOAD  = 2'b01,
        READY = 2'b10
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_err;
    logic                  start;
    logic                  im_valid;
    logic [DATA_WIDTH-1:0] im_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic at_top;
    logic finish_load;
    logic fetch;
    logic in_range;

    // reload takes priority over both a host word and a fetch in the same cycle
    assign accept      = bus.load_valid_i && (state != READY) && !bus.reload_i;
    assign at_top      = (wr_ptr == ADDR_WIDTH'(DEPTH - 1));
    assign finish_load = bus.load_last_i || at_top;
    assign fetch       = (state == READY) && bus.im_rd_i && !bus.reload_i;
    assign in_range    = ({1'b0, bus.im_addr_i} < load_count);

    // program storage survives reset and reload; only the load port writes it
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.load_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            wr_ptr     <= '0;
            load_count <= '0;
            load_err   <= 1'b0;
            start      <= 1'b0;
            im_valid   <= 1'b0;
            im_data    <= '0;
        end else begin
            start    <= 1'b0;
            im_valid <= fetch;
            if (fetch) begin
                im_data <= in_range ? mem[bus.im_addr_i] : '0;
            end

            if (bus.reload_i) begin
                state      <= EMPTY;
                wr_ptr     <= '0;
                load_count <= '0;
                load_err   <= 1'b0;
            end else if (accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                load_count <= load_count + 1'b1;
                if (finish_load) begin
                    state <= READY;
                    start <= 1'b1;
                    if (!bus.load_last_i) begin
                        load_err <= 1'b1;
                    end
                end else begin
                    state <= LOAD;
                end
            end
        end
    end

    assign bus.load_ready_o = (state != READY);
    assign bus.im_data_o    = im_data;
    assign bus.im_valid_o   = im_valid;
    assign bus.start_o      = start;
    assign bus.load_count_o = load_count;
    assign bus.load_err_o   = load_err;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - directed self-checking bench for instr_mem_ctrl
module tb_instr_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    instr_mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    instr_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
        bus.reload_i     = 1'b0;
        bus.im_rd_i      = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = d;
        bus.load_last_i  = last;
        tick();
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        bus.im_rd_i   = 1'b1;
        bus.im_addr_i = a;
        tick();
        bus.im_rd_i   = 1'b0;
    endtask

    initial begin
        idle();
        bus.load_data_i = '0;
        bus.im_addr_i   = '0;

        // reset state
        #2;
        chk("rst_state", 32'(bus.state_o), 32'h0);
        chk("rst_count", 32'(bus.load_count_o), 32'h0);
        chk("rst_err", 32'(bus.load_err_o), 32'h0);
        chk("rst_start", 32'(bus.start_o), 32'h0);
        chk("rst_valid", 32'(bus.im_valid_o), 32'h0);
        chk("rst_data", 32'(bus.im_data_o), 32'h0);
        chk("rst_ready", 32'(bus.load_ready_o), 32'h1);
        tick();
        rst = 1'b0;
        tick();

        // three-word program
        push(16'h1111, 1'b0);
        chk("l3_state1", 32'(bus.state_o), 32'h1);
        chk("l3_count1", 32'(bus.load_count_o), 32'h1);
        push(16'h2222, 1'b0);
        chk("l3_state2", 32'(bus.state_o), 32'h1);
        push(16'h3333, 1'b1);
        chk("l3_state3", 32'(bus.state_o), 32'h2);
        chk("l3_count3", 32'(bus.load_count_o), 32'h3);
        chk("l3_start", 32'(bus.start_o), 32'h1);
        chk("l3_ready", 32'(bus.load_ready_o), 32'h0);
        tick();
        chk("l3_start_clr", 32'(bus.start_o), 32'h0);
        chk("l3_err", 32'(bus.load_err_o), 32'h0);

        // back-to-back fetch including one past the program
        bus.im_rd_i = 1'b1;
        bus.im_addr_i = 8'd0; tick();
        chk("f0_valid", 32'(bus.im_valid_o), 32'h1);
        chk("f0_data", 32'(bus.im_data_o), 32'h1111);
        bus.im_addr_i = 8'd1; tick();
        chk("f1_valid", 32'(bus.im_valid_o), 32'h1);
        chk("f1_data", 32'(bus.im_data_o), 32'h2222);
        bus.im_addr_i = 8'd2; tick();
        chk("f2_data", 32'(bus.im_data_o), 32'h3333);
        bus.im_addr_i = 8'd3; tick();
        chk("f3_valid", 32'(bus.im_valid_o), 32'h1);
        chk("f3_nop", 32'(bus.im_data_o), 32'h0);
        bus.im_rd_i = 1'b0;
        rd(8'd1);
        chk("f1b_data", 32'(bus.im_data_o), 32'h2222);
        tick();
        chk("idle_valid", 32'(bus.im_valid_o), 32'h0);
        chk("idle_hold", 32'(bus.im_data_o), 32'h2222);

        // host word in READY is ignored
        push(16'hFFFF, 1'b1);
        chk("rdy_ign_count", 32'(bus.load_count_o), 32'h3);
        chk("rdy_ign_start", 32'(bus.start_o), 32'h0);

        // reload beats a same-cycle read
        bus.reload_i = 1'b1;
        rd(8'd0);
        bus.reload_i = 1'b0;
        chk("rl_valid", 32'(bus.im_valid_o), 32'h0);
        chk("rl_hold", 32'(bus.im_data_o), 32'h2222);
        chk("rl_state", 32'(bus.state_o), 32'h0);
        chk("rl_count", 32'(bus.load_count_o), 32'h0);
        chk("rl_err", 32'(bus.load_err_o), 32'h0);
        chk("rl_ready", 32'(bus.load_ready_o), 32'h1);

        // read while EMPTY is not serviced
        rd(8'd0);
        chk("empty_rd_valid", 32'(bus.im_valid_o), 32'h0);
        chk("empty_rd_hold", 32'(bus.im_data_o), 32'h2222);

        // single word with last straight from EMPTY
        push(16'h5A5A, 1'b1);
        chk("one_state", 32'(bus.state_o), 32'h2);
        chk("one_count", 32'(bus.load_count_o), 32'h1);
        chk("one_start", 32'(bus.start_o), 32'h1);
        rd(8'd0);
        chk("one_rd0", 32'(bus.im_data_o), 32'h5A5A);
        chk("one_start_clr", 32'(bus.start_o), 32'h0);
        rd(8'd1);
        chk("one_rd1_valid", 32'(bus.im_valid_o), 32'h1);
        chk("one_rd1_nop", 32'(bus.im_data_o), 32'h0);

        // 256 words without last: fill, READY, sticky error
        bus.reload_i = 1'b1; tick(); bus.reload_i = 1'b0;
        for (int i = 0; i < 256; i++) begin
            push(16'(i * 3 + 7), 1'b0);
            if (i == 0) chk("full_state_first", 32'(bus.state_o), 32'h1);
            if (i == 1) rd(8'd0);
            if (i == 1) chk("load_rd_valid", 32'(bus.im_valid_o), 32'h0);
            if (i == 254) chk("full_state_254", 32'(bus.state_o), 32'h1);
        end
        chk("full_state", 32'(bus.state_o), 32'h2);
        chk("full_count", 32'(bus.load_count_o), 32'd256);
        chk("full_err", 32'(bus.load_err_o), 32'h1);
        chk("full_start", 32'(bus.start_o), 32'h1);
        chk("full_ready", 32'(bus.load_ready_o), 32'h0);
        push(16'hDEAD, 1'b0);
        chk("full_no_more", 32'(bus.load_count_o), 32'd256);
        rd(8'd255);
        chk("full_rd255", 32'(bus.im_data_o), 32'h0304);
        rd(8'd0);
        chk("full_rd0", 32'(bus.im_data_o), 32'h0007);
        chk("full_err_sticky", 32'(bus.load_err_o), 32'h1);

        // asynchronous reset mid-load
        bus.reload_i = 1'b1; tick(); bus.reload_i = 1'b0;
        chk("rl2_err", 32'(bus.load_err_o), 32'h0);
        push(16'h0A0A, 1'b0);
        push(16'h0B0B, 1'b0);
        chk("mid_count", 32'(bus.load_count_o), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state_o), 32'h0);
        chk("arst_count", 32'(bus.load_count_o), 32'h0);
        chk("arst_valid", 32'(bus.im_valid_o), 32'h0);
        chk("arst_data", 32'(bus.im_data_o), 32'h0);
        rst = 1'b0;
        push(16'hABCD, 1'b1);
        chk("post_rst_count", 32'(bus.load_count_o), 32'h1);
        chk("post_rst_state", 32'(bus.state_o), 32'h2);
        rd(8'd0);
        chk("post_rst_rd0", 32'(bus.im_data_o), 32'hABCD);
        chk("post_rst_valid", 32'(bus.im_valid_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
